// File: rtl/raw_capture_ctrl.sv
// Frame-capture controller between the raw Bayer sensor port and the RAW2GRAY datapath.
// Aligns capture to sensor frame boundaries, emits a registered pixel/col/row stream and flags length errors.
module raw_capture_ctrl #(
    parameter int DATA_WIDTH = 12,
    parameter int IMG_WIDTH  = 1280,
    parameter int IMG_HEIGHT = 960,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  sensor_fval,
    input  logic                  sensor_lval,
    input  logic                  sensor_dval,
    input  logic [DATA_WIDTH-1:0] sensor_data,
    output logic [DATA_WIDTH-1:0] pixel,
    output logic                  pixel_valid,
    output logic [CNT_WIDTH-1:0]  col_num,
    output logic [CNT_WIDTH-1:0]  row_num,
    output logic                  busy,
    output logic                  frame_done,
    output logic [CNT_WIDTH-1:0]  frame_count,
    output logic                  line_err
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0] COL_MAX = CNT_WIDTH'(IMG_WIDTH);
    localparam logic [CNT_WIDTH-1:0] ROW_MAX = CNT_WIDTH'(IMG_HEIGHT);

    state_t               state;
    logic                 fval_d;
    logic                 lval_d;
    logic                 stop_pending;
    logic                 line_ovf;
    logic [CNT_WIDTH-1:0] col_cnt;
    logic [CNT_WIDTH-1:0] row_cnt;

    logic                 frame_rise;
    logic                 frame_fall;
    logic                 line_fall;
    logic                 pix_qual;
    logic                 accept;
    logic                 overflow;
    logic                 line_bad;
    logic [CNT_WIDTH-1:0] row_after_line;

    assign frame_rise = sensor_fval & ~fval_d;
    assign frame_fall = ~sensor_fval & fval_d;
    assign line_fall  = ~sensor_lval & lval_d & fval_d;
    assign pix_qual   = (state == CAPTURE) & sensor_fval & sensor_lval & sensor_dval;
    assign accept     = pix_qual & (col_cnt < COL_MAX) & (row_cnt < ROW_MAX);
    // Pixels beyond the line width are dropped but remembered so the line still reports an error.
    assign overflow   = pix_qual & (col_cnt >= COL_MAX);
    assign line_bad   = line_fall & ((col_cnt != COL_MAX) | line_ovf);

    // The frame check must see the row count as if a coincident line end had already been counted.
    assign row_after_line = (line_fall && row_cnt < ROW_MAX) ? row_cnt + 1'b1 : row_cnt;

    // NOTE: all state uses non-blocking assignments; where two branches write the same register
    // in one cycle, the textually later assignment wins, which the frame-end clearing relies on.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            fval_d       <= 1'b0;
            lval_d       <= 1'b0;
            stop_pending <= 1'b0;
            line_ovf     <= 1'b0;
            col_cnt      <= '0;
            row_cnt      <= '0;
            pixel        <= '0;
            pixel_valid  <= 1'b0;
            col_num      <= '0;
            row_num      <= '0;
            busy         <= 1'b0;
            frame_done   <= 1'b0;
            frame_count  <= '0;
            line_err     <= 1'b0;
        end else begin
            fval_d      <= sensor_fval;
            lval_d      <= sensor_lval;
            frame_done  <= 1'b0;
            pixel_valid <= accept;

            if (accept) begin
                pixel   <= sensor_data;
                col_num <= col_cnt;
                row_num <= row_cnt;
                col_cnt <= col_cnt + 1'b1;
            end
            if (overflow) begin
                line_ovf <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (start && !stop) begin
                        state       <= ARM;
                        busy        <= 1'b1;
                        line_err    <= 1'b0;
                        frame_count <= '0;
                    end
                end

                ARM: begin
                    if (stop) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (frame_rise) begin
                        state    <= CAPTURE;
                        col_cnt  <= '0;
                        row_cnt  <= '0;
                        line_ovf <= 1'b0;
                    end
                end

                CAPTURE: begin
                    if (stop) begin
                        stop_pending <= 1'b1;
                    end
                    if (line_fall) begin
                        col_cnt  <= '0;
                        row_cnt  <= row_after_line;
                        line_ovf <= 1'b0;
                        if (line_bad) begin
                            line_err <= 1'b1;
                        end
                    end
                    if (frame_fall) begin
                        col_cnt     <= '0;
                        row_cnt     <= '0;
                        line_ovf    <= 1'b0;
                        frame_done  <= 1'b1;
                        frame_count <= frame_count + 1'b1;
                        if (row_after_line != ROW_MAX) begin
                            line_err <= 1'b1;
                        end
                        if (stop_pending || stop) begin
                            state        <= IDLE;
                            busy         <= 1'b0;
                            stop_pending <= 1'b0;
                        end else begin
                            state <= ARM;
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_raw_capture_ctrl.sv
// Randomized scoreboard bench for raw_capture_ctrl on a small 8x4 image.
// Frames are described as per-line pixel counts; a behavioural model predicts the pixel stream and status.
module tb_raw_capture_ctrl;

    localparam int DW = 12;
    localparam int CW = 16;
    localparam int W  = 8;
    localparam int H  = 4;

    typedef enum {M_IDLE, M_ARMED, M_CAPT} mode_t;

    typedef struct {
        logic [DW-1:0] data;
        logic [CW-1:0] col;
        logic [CW-1:0] row;
        int            stamp;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic          sensor_fval = 1'b0;
    logic          sensor_lval = 1'b0;
    logic          sensor_dval = 1'b0;
    logic [DW-1:0] sensor_data = '0;
    logic [DW-1:0] pixel;
    logic          pixel_valid;
    logic [CW-1:0] col_num;
    logic [CW-1:0] row_num;
    logic          busy;
    logic          frame_done;
    logic [CW-1:0] frame_count;
    logic          line_err;

    raw_capture_ctrl #(
        .DATA_WIDTH(DW),
        .IMG_WIDTH (W),
        .IMG_HEIGHT(H),
        .CNT_WIDTH (CW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .stop       (stop),
        .sensor_fval(sensor_fval),
        .sensor_lval(sensor_lval),
        .sensor_dval(sensor_dval),
        .sensor_data(sensor_data),
        .pixel      (pixel),
        .pixel_valid(pixel_valid),
        .col_num    (col_num),
        .row_num    (row_num),
        .busy       (busy),
        .frame_done (frame_done),
        .frame_count(frame_count),
        .line_err   (line_err)
    );

    always #5 clk = ~clk;

    int    cyc = 0;
    int    n_checks = 0;
    int    n_pass = 0;
    exp_t  sb[$];
    int    line_len[16];

    mode_t mode = M_IDLE;
    bit    stop_req = 1'b0;
    bit    exp_err = 1'b0;
    int    exp_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    endtask

    // Monitor: every expected beat must appear exactly one cycle after its input, nothing else may.
    always @(negedge clk) begin
        if (rst) begin
            if (sb.size() > 0 && sb[0].stamp == cyc) begin
                exp_t e;
                e = sb.pop_front();
                check("pixel_valid", 64'(pixel_valid), 64'(1'b1));
                check("pixel_beat", 64'({pixel, col_num, row_num}), 64'({e.data, e.col, e.row}));
            end else if (pixel_valid) begin
                check("unexpected_pixel_valid", 64'(pixel_valid), 64'(1'b0));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Inputs change 1 time unit after the active edge; start/stop are one-cycle pulses.
    task automatic tick();
        @(posedge clk);
        #1;
        start = 1'b0;
        stop  = 1'b0;
    endtask

    task automatic drive(input logic f, input logic l, input logic dv, input logic [DW-1:0] d);
        tick();
        sensor_fval = f;
        sensor_lval = l;
        sensor_dval = dv;
        sensor_data = d;
    endtask

    task automatic settle();
        tick();
        @(negedge clk);
    endtask

    task automatic pulse(input logic s, input logic p);
        tick();
        start       = s;
        stop        = p;
        sensor_dval = 1'b0;
        if (mode == M_IDLE) begin
            if (s && !p) begin
                mode    = M_ARMED;
                exp_err = 1'b0;
                exp_cnt = 0;
            end
        end else if (p) begin
            if (mode == M_ARMED) mode = M_IDLE;
            else stop_req = 1'b1;
        end
    endtask

    task automatic set_full_lines();
        for (int i = 0; i < 16; i++) line_len[i] = W;
    endtask

    // dmode: 0 = dval always high, 1 = dval on alternate cycles, 2 = random dval gaps.
    task automatic send_frame(input int nlines, input int dmode, input bit seq_data, input bit abrupt,
                              input int pulse_line, input logic ps, input logic pp);
        bit            capt;
        bit            pulsed;
        bit            gap;
        int            n;
        int            k;
        int            slot;
        logic [DW-1:0] d;
        pulsed = 1'b0;
        drive(1'b1, 1'b0, 1'b0, '0);
        capt = (mode == M_ARMED);
        if (capt) mode = M_CAPT;
        drive(1'b1, 1'b0, 1'b0, '0);
        for (int li = 0; li < nlines; li++) begin
            n    = line_len[li];
            k    = 0;
            slot = 0;
            while (k < n) begin
                if (li == pulse_line && k == 2 && !pulsed) begin
                    pulse(ps, pp);
                    pulsed = 1'b1;
                end
                gap = (dmode == 1 && slot % 2 == 1) || (dmode == 2 && $urandom_range(2) == 0);
                slot++;
                if (gap) begin
                    drive(1'b1, 1'b1, 1'b0, DW'($urandom));
                end else begin
                    d = seq_data ? DW'(li * W + k) : DW'($urandom);
                    drive(1'b1, 1'b1, 1'b1, d);
                    if (capt && li < H && k < W) sb.push_back('{d, CW'(k), CW'(li), cyc + 1});
                    k++;
                end
            end
            if (capt && n != W) exp_err = 1'b1;
            if (!(abrupt && li == nlines - 1)) begin
                drive(1'b1, 1'b0, 1'b0, '0);
                drive(1'b1, 1'b0, 1'b0, '0);
            end
        end
        if (capt && nlines != H) exp_err = 1'b1;
        drive(1'b0, 1'b0, 1'b0, '0);
        if (capt) begin
            exp_cnt++;
            mode     = stop_req ? M_IDLE : M_ARMED;
            stop_req = 1'b0;
        end
        settle();
        check("frame_done", 64'(frame_done), 64'(capt));
        check("frame_count", 64'(frame_count), 64'(exp_cnt));
        check("line_err", 64'(line_err), 64'(exp_err));
        settle();
        check("busy_after_frame", 64'(busy), 64'(mode != M_IDLE));
        drive(1'b0, 1'b0, 1'b0, '0);
        drive(1'b0, 1'b0, 1'b0, '0);
    endtask

    initial begin
        logic [DW-1:0] d;
        #23;
        rst = 1'b1;
        settle();
        check("reset_busy", 64'(busy), 64'(1'b0));
        check("reset_pixel_valid", 64'(pixel_valid), 64'(1'b0));
        check("reset_frame_count", 64'(frame_count), 64'(0));
        check("reset_line_err", 64'(line_err), 64'(1'b0));
        check("reset_outputs", 64'({pixel, col_num, row_num, frame_done}), 64'(0));

        // Clean frame with data = row*8+col.
        set_full_lines();
        pulse(1'b1, 1'b0);
        send_frame(H, 0, 1'b1, 1'b0, -1, 1'b0, 1'b0);

        // Stop from ARM, then start while a frame is already running: that frame is skipped.
        pulse(1'b0, 1'b1);
        settle();
        check("busy_after_arm_stop", 64'(busy), 64'(1'b0));
        send_frame(H, 0, 1'b1, 1'b0, 1, 1'b1, 1'b0);
        send_frame(H, 0, 1'b1, 1'b0, -1, 1'b0, 1'b0);

        // Short then long line: error sticks across the following clean frame.
        line_len[0] = 6;
        line_len[1] = 10;
        send_frame(H, 0, 1'b0, 1'b0, -1, 1'b0, 1'b0);
        set_full_lines();
        send_frame(H, 0, 1'b1, 1'b0, -1, 1'b0, 1'b0);

        // dval on alternate cycles.
        send_frame(H, 1, 1'b1, 1'b0, -1, 1'b0, 1'b0);

        // Stop during line 2: frame completes, next frame ignored.
        send_frame(H, 0, 1'b1, 1'b0, 2, 1'b0, 1'b1);
        send_frame(H, 0, 1'b1, 1'b0, -1, 1'b0, 1'b0);
        pulse(1'b1, 1'b1);
        settle();
        check("busy_start_and_stop", 64'(busy), 64'(1'b0));
        pulse(1'b1, 1'b0);
        settle();
        check("busy_after_start", 64'(busy), 64'(1'b1));
        check("line_err_cleared", 64'(line_err), 64'(1'b0));
        check("frame_count_cleared", 64'(frame_count), 64'(0));

        // Randomized frames: odd line lengths, extra lines, dval gaps, ignored start mid-capture.
        for (int f = 0; f < 6; f++) begin
            int nl;
            nl = ($urandom_range(5) == 0) ? H + 1 : H;
            for (int i = 0; i < 16; i++) begin
                int r;
                r = $urandom_range(5);
                line_len[i] = (r == 0) ? W - 1 : (r == 1) ? W + 2 : W;
            end
            send_frame(nl, 2, 1'b0, bit'($urandom_range(1)), 1, 1'b1, 1'b0);
        end
        set_full_lines();
        send_frame(H, 0, 1'b0, 1'b1, -1, 1'b0, 1'b0);

        // Asynchronous reset in the middle of line 0 of a captured frame.
        drive(1'b1, 1'b0, 1'b0, '0);
        if (mode == M_ARMED) mode = M_CAPT;
        drive(1'b1, 1'b0, 1'b0, '0);
        for (int k = 0; k < 3; k++) begin
            d = DW'($urandom);
            drive(1'b1, 1'b1, 1'b1, d);
            if (mode == M_CAPT) sb.push_back('{d, CW'(k), CW'(0), cyc + 1});
        end
        #2;
        rst = 1'b0;
        #1;
        check("async_rst_pixel_valid", 64'(pixel_valid), 64'(1'b0));
        check("async_rst_busy", 64'(busy), 64'(1'b0));
        check("async_rst_status", 64'({frame_count, line_err}), 64'(0));
        check("async_rst_stream", 64'({pixel, col_num, row_num}), 64'(0));
        sb.delete();
        mode     = M_IDLE;
        stop_req = 1'b0;
        exp_cnt  = 0;
        exp_err  = 1'b0;
        drive(1'b1, 1'b1, 1'b1, DW'($urandom));
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 4; k++) drive(1'b1, 1'b1, 1'b1, DW'($urandom));
        drive(1'b1, 1'b0, 1'b0, '0);
        drive(1'b1, 1'b0, 1'b0, '0);
        settle();
        check("no_capture_without_start", 64'(busy), 64'(1'b0));
        pulse(1'b1, 1'b0);
        for (int li = 1; li < H; li++) begin
            for (int k = 0; k < W; k++) drive(1'b1, 1'b1, 1'b1, DW'($urandom));
            drive(1'b1, 1'b0, 1'b0, '0);
        end
        drive(1'b0, 1'b0, 1'b0, '0);
        settle();
        check("partial_frame_no_done", 64'(frame_done), 64'(1'b0));
        check("armed_after_partial", 64'(busy), 64'(1'b1));
        drive(1'b0, 1'b0, 1'b0, '0);
        send_frame(H, 0, 1'b1, 1'b0, -1, 1'b0, 1'b0);

        repeat (4) settle();
        check("scoreboard_drained", 64'(sb.size()), 64'(0));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
